// File: rtl/router_pkg.sv
// Shared router constants: packet geometry, requester indices and the dx field extractor.
package router_pkg;

    localparam int unsigned PKT_W  = 16;
    localparam int unsigned DX_LSB = 4;
    localparam int unsigned DX_W   = 4;

    localparam int unsigned REQ_WEST  = 0;
    localparam int unsigned REQ_LOCAL = 1;
    localparam int unsigned REQ_TURN  = 2;

    function automatic logic signed [DX_W-1:0] dx_of(input logic [PKT_W-1:0] pkt);
        return pkt[DX_LSB +: DX_W];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = int'(unsigned'(ptr)) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (en && !found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/east_port_arbiter.sv
// East output link arbiter: round-robin over requesters into a one-entry output register,
// dropping and counting packets whose signed dx field is negative.
module east_port_arbiter #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned PKT_W  = router_pkg::PKT_W,
    parameter int unsigned DX_LSB = router_pkg::DX_LSB,
    parameter int unsigned DX_W   = router_pkg::DX_W,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned SRC_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*PKT_W-1:0] req_packet,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [PKT_W-1:0]       out_packet,
    output logic [SRC_W-1:0]       out_src,
    input  logic                   out_ready,
    input  logic                   clr_err,
    output logic                   err_dx_neg,
    output logic [CNT_W-1:0]       drop_count
);

    import router_pkg::*;

    logic             out_valid_q, out_valid_d;
    logic [PKT_W-1:0] out_packet_q, out_packet_d;
    logic [SRC_W-1:0] out_src_q, out_src_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             slot_free;
    logic [N_REQ-1:0] grant;
    logic [SRC_W-1:0] gidx;
    logic [PKT_W-1:0] gpkt;
    logic             xfer;
    logic             dx_neg;
    logic             load;
    logic             drop;

    assign slot_free = !out_valid_q || out_ready;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (SRC_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .en    (slot_free),
        .grant (grant),
        .idx   (gidx)
    );

    // Ready is held low for the whole reset window, not just after the first edge.
    assign req_ready = grant & {N_REQ{rst_n}};

    always_comb begin
        gpkt = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gpkt = gpkt | req_packet[i*PKT_W +: PKT_W];
            end
        end
    end

    assign xfer   = |(req_valid & req_ready);
    assign dx_neg = gpkt[DX_LSB + DX_W - 1];
    assign load   = xfer && !dx_neg;
    assign drop   = xfer && dx_neg;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_packet_d = out_packet_q;
        out_src_d    = out_src_q;
        if (load) begin
            out_valid_d  = 1'b1;
            out_packet_d = gpkt;
            out_src_d    = gidx;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (gidx == SRC_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
        end
    end

    // Clear takes priority over a drop landing in the same cycle.
    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (clr_err) begin
            err_d = 1'b0;
            cnt_d = '0;
        end else if (drop) begin
            err_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_packet_q <= '0;
            out_src_q    <= '0;
            rr_ptr_q     <= SRC_W'(REQ_WEST);
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_packet_q <= out_packet_d;
            out_src_q    <= out_src_d;
            rr_ptr_q     <= rr_ptr_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_packet = out_packet_q;
    assign out_src    = out_src_q;
    assign err_dx_neg = err_q;
    assign drop_count = cnt_q;

    a_ptr_range: assert property (@(posedge clk) disable iff (!rst_n)
        rr_ptr_q < SRC_W'(N_REQ));
    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));
    a_hold_stall: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_q && !out_ready) |=> $stable(out_packet_q) && $stable(out_src_q));

endmodule

// File: tb/tb_east_port_arbiter.sv
// Directed bench for east_port_arbiter with a scoreboard of expected output-register contents.
module tb_east_port_arbiter;

    import router_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned PW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*PW-1:0] req_packet;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [PW-1:0]   out_packet;
    logic [1:0]      out_src;
    logic            out_ready;
    logic            clr_err;
    logic            err_dx_neg;
    logic [7:0]      drop_count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [PW-1:0] pkt;
        logic [1:0]    src;
    } entry_t;

    entry_t     q[$];
    int         m_ptr = 0;
    logic       m_err = 1'b0;
    int         m_cnt = 0;
    logic       m_go = 1'b0, m_pop = 1'b0, m_xfer = 1'b0, m_clr = 1'b0;
    int         m_g = 0;
    logic [PW-1:0] m_pkt = '0;

    east_port_arbiter u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_packet (req_packet),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_packet (out_packet),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .clr_err    (clr_err),
        .err_dx_neg (err_dx_neg),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: sample at negedge, commit at the following posedge.
    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        logic         found;
        int           g;
        int           idx;
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 32'h0);
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            m_go = 1'b0;
        end else begin
            exp_ready = '0;
            found     = 1'b0;
            g         = 0;
            if (q.size() == 0 || out_ready) begin
                for (int off = 0; off < N; off++) begin
                    idx = (m_ptr + off) % N;
                    if (!found && req_valid[idx]) begin
                        found = 1'b1;
                        g     = idx;
                    end
                end
            end
            if (found) exp_ready[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("err_dx_neg", 32'(err_dx_neg), 32'(m_err));
            chk("drop_count", 32'(drop_count), 32'(m_cnt));
            m_pop = (q.size() != 0) && out_ready;
            if (m_pop) begin
                chk("drain_pkt", 32'(out_packet), 32'(q[0].pkt));
                chk("drain_src", 32'(out_src), 32'(q[0].src));
            end
            m_xfer = found;
            m_g    = g;
            m_pkt  = req_packet[g*PW +: PW];
            m_clr  = clr_err;
            m_go   = 1'b1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ptr = 0;
            m_err = 1'b0;
            m_cnt = 0;
            m_go  = 1'b0;
        end else if (m_go) begin
            if (m_pop) void'(q.pop_front());
            if (m_xfer) begin
                m_ptr = (m_g + 1) % N;
                if (dx_of(m_pkt) < 0) begin
                    m_err = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    q.push_back('{pkt: m_pkt, src: 2'(m_g)});
                end
            end
            if (m_clr) begin
                m_err = 1'b0;
                m_cnt = 0;
            end
            m_go = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input int i, input logic [PW-1:0] p);
        req_packet[i*PW +: PW] = p;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_packet = '0;
        out_ready  = 1'b0;
        clr_err    = 1'b0;
        #2;
        req_valid = 3'b111;
        repeat (3) @(negedge clk);
        chk("rst_err", 32'(err_dx_neg), 32'h0);
        chk("rst_cnt", 32'(drop_count), 32'h0);
        cyc();
        rst_n     = 1'b1;
        req_valid = '0;

        // Round-robin fairness with all three requesters
        set_pkt(REQ_WEST, 16'h0110);
        set_pkt(REQ_LOCAL, 16'h0220);
        set_pkt(REQ_TURN, 16'h0330);
        req_valid = 3'b111;
        out_ready = 1'b1;
        @(negedge clk); chk("rr_g0", 32'(req_ready), 32'b001);
        @(negedge clk); chk("rr_g1", 32'(req_ready), 32'b010);
        chk("rr_src0", 32'(out_src), 32'd0);
        @(negedge clk); chk("rr_g2", 32'(req_ready), 32'b100);
        chk("rr_src1", 32'(out_src), 32'd1);
        @(negedge clk); chk("rr_g3", 32'(req_ready), 32'b001);
        chk("rr_src2", 32'(out_src), 32'd2);
        cyc();

        // Back-pressure holds the register and blocks all grants
        req_valid = 3'b010;
        out_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_pkt", 32'(out_packet), 32'h0110);
            chk("bp_src", 32'(out_src), 32'd0);
        end
        cyc();
        out_ready = 1'b1;
        @(negedge clk); chk("bp_release", 32'(req_ready), 32'b010);
        cyc();
        chk("bp_swap_pkt", 32'(out_packet), 32'h0220);
        chk("bp_swap_valid", 32'(out_valid), 32'h1);

        // Negative dx is consumed and flagged, dx = 0 passes
        req_valid = '0;
        cyc();
        set_pkt(REQ_LOCAL, 16'h00F0);
        req_valid = 3'b010;
        @(negedge clk); chk("neg_ready", 32'(req_ready), 32'b010);
        cyc();
        req_valid = '0;
        chk("neg_valid", 32'(out_valid), 32'h0);
        chk("neg_err", 32'(err_dx_neg), 32'h1);
        chk("neg_cnt", 32'(drop_count), 32'h1);
        set_pkt(REQ_LOCAL, 16'h0005);
        req_valid = 3'b010;
        cyc();
        req_valid = '0;
        chk("zero_valid", 32'(out_valid), 32'h1);
        chk("zero_pkt", 32'(out_packet), 32'h0005);
        chk("zero_src", 32'(out_src), 32'd1);

        // Saturation, then clear colliding with a drop
        set_pkt(REQ_LOCAL, 16'h00F0);
        req_valid = 3'b010;
        repeat (300) cyc();
        chk("sat_cnt", 32'(drop_count), 32'd255);
        chk("sat_err", 32'(err_dx_neg), 32'h1);
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        chk("clr_err", 32'(err_dx_neg), 32'h0);
        chk("clr_cnt", 32'(drop_count), 32'h0);

        // Skip an idle requester across the wrap
        set_pkt(REQ_WEST, 16'h0110);
        set_pkt(REQ_TURN, 16'h0330);
        req_valid = 3'b001;
        @(negedge clk); chk("skip_pre", 32'(req_ready), 32'b001);
        cyc();
        req_valid = 3'b101;
        @(negedge clk); chk("skip_g2a", 32'(req_ready), 32'b100);
        @(negedge clk); chk("skip_g0", 32'(req_ready), 32'b001);
        @(negedge clk); chk("skip_g2b", 32'(req_ready), 32'b100);
        cyc();

        // Reset with a packet held in the output register
        out_ready = 1'b0;
        req_valid = 3'b111;
        chk("mid_valid_pre", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(out_valid), 32'h0);
        chk("mid_pkt", 32'(out_packet), 32'h0);
        chk("mid_src", 32'(out_src), 32'h0);
        chk("mid_ready", 32'(req_ready), 32'h0);
        cyc();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk); chk("post_rst_grant", 32'(req_ready), 32'b001);
        chk("post_rst_pkt", 32'(out_packet), 32'h0);
        cyc();
        req_valid = '0;
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
